// File: rtl/sensor_pkg.sv
// Shared constants for the line-sensor front end: channel map and filter defaults.
// Controllers index sensor_out with the SENSOR_* constants.
package sensor_pkg;

  localparam int N_SENSORS = 3;

  localparam int SENSOR_L = 2;
  localparam int SENSOR_M = 1;
  localparam int SENSOR_R = 0;

  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_STABLE_CYCLES = 4;

  // A one-cycle debounce still needs a counter bit to keep the datapath uniform.
  function automatic int cnt_width(input int stable_cycles);
    return (stable_cycles > 1) ? $clog2(stable_cycles) : 1;
  endfunction

endpackage

// File: rtl/sensor_filter_ch.sv
// One conditioned channel: synchroniser chain, debounce counter, filtered level
// and registered rise/fall pulses.
module sensor_filter_ch
  import sensor_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic accept
);

  localparam int CNT_W = cnt_width(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0]       cnt;
  logic                   s;

  assign s = sync[SYNC_STAGES-1];

  // Exposed unregistered so the top can register its OR in the same edge as rise/fall.
  assign accept = (s != dout) && (cnt == CNT_MAX);

  // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= '0;
      cnt  <= '0;
      dout <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din};
      rise <= 1'b0;
      fall <= 1'b0;
      if (s == dout) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        dout <= s;
        cnt  <= '0;
        rise <= s;
        fall <= ~s;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/sensor_filter.sv
// Multi-channel input conditioner: N_CH independent synchronise+debounce channels
// plus a registered "any edge" flag for the line-following controller.
module sensor_filter
  import sensor_pkg::*;
#(
  parameter int N_CH          = N_SENSORS,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] sensor_in,
  output logic [N_CH-1:0] sensor_out,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic            changed
);

  logic [N_CH-1:0] accept;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    sensor_filter_ch #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_ch (
      .clk   (clk),
      .reset (reset),
      .din   (sensor_in[i]),
      .dout  (sensor_out[i]),
      .rise  (rise[i]),
      .fall  (fall[i]),
      .accept(accept[i])
    );
  end

  // Same-edge registration keeps changed aligned with the per-channel pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      changed <= 1'b0;
    end else begin
      changed <= |accept;
    end
  end

endmodule

// File: doc/sensor_filter.md
# sensor_filter

Parametrised input conditioner for the robot's line sensors and other asynchronous digital inputs. Each of `N_CH` channels passes through a `SYNC_STAGES`-deep synchroniser followed by a per-channel debounce counter. The counter accepts a new level only after it has held for `STABLE_CYCLES` consecutive clocks. The block sits between the sensor pins and the line-following controller, and also emits single-cycle rise/fall event pulses so the controller needs no edge logic of its own.

## Interface

Parameters:
- `N_CH`, default 3: number of input channels.
- `SYNC_STAGES`, default 2: synchroniser flop count; legal values ≥ 2.
- `STABLE_CYCLES`, default 4: consecutive clocks a new synchronised level must hold before it is accepted; legal values ≥ 1.

Ports:
- `clk`, input, 1 bit: single clock; all flops are rising-edge.
- `reset`, input, 1 bit: synchronous, active-high.
- `sensor_in`, input, `N_CH` bits: raw asynchronous inputs.
- `sensor_out`, output, `N_CH` bits: filtered, registered levels.
- `rise`, output, `N_CH` bits: one-cycle pulse when `sensor_out[i]` goes 0→1.
- `fall`, output, `N_CH` bits: one-cycle pulse when `sensor_out[i]` goes 1→0.
- `changed`, output, 1 bit: registered OR of all `rise` and `fall` bits in the same cycle.

## Operation

- Channels are fully independent. Bit `i` of every vector belongs to channel `i`.
- Synchroniser:
  - `SYNC_STAGES` flops per channel.
  - The last stage is the channel's sampled level `s[i]`.
- Debounce, evaluated per channel on each rising edge of `clk` with `reset` low:
  - If `s == sensor_out`: `cnt <= 0`.
  - Else if `cnt == STABLE_CYCLES-1`: `sensor_out <= s`, `cnt <= 0`, and `rise` or `fall` is set for one cycle according to the new level.
  - Else: `cnt <= cnt + 1`.
- `cnt` width is `$clog2(STABLE_CYCLES)`, with a minimum of 1 bit. `cnt` never exceeds `STABLE_CYCLES-1`, so it cannot wrap.
- Glitch rejection:
  - Any excursion of `s` shorter than `STABLE_CYCLES` cycles clears the counter and produces no output change.
  - A bounce back to the current output level restarts the count from 0. There is no partial credit.
- `rise`/`fall` behaviour:
  - Both are registered and coincide with the `sensor_out` update.
  - Both are low in every other cycle.
  - `rise[i]` and `fall[i]` are never high together.
- `changed` is high in exactly the cycles in which any `rise` or `fall` bit is high.
- Reset:
  - Clears all synchroniser flops, counters, `sensor_out`, `rise`, `fall` and `changed` to 0.
  - Takes priority over all other behaviour.
  - A reset arriving mid-count discards the count; no pulse is emitted in or after the reset cycle for the interrupted transition.
- After reset release with an input held at 1, the channel reports a normal 0→1 transition, including the `rise` pulse, after the full latency.

## Timing

- Latency: an input change set up before edge 1 and held stable appears on `sensor_out` after edge `SYNC_STAGES + STABLE_CYCLES`.
  - With defaults this is edge 6.
  - With `STABLE_CYCLES=1` the block reduces to a plain synchroniser with latency `SYNC_STAGES + 1`.
- Minimum accepted pulse width at `sensor_in` is `STABLE_CYCLES` cycles. Shorter pulses are always rejected, provided they are not merged by synchroniser metastability.
- Simultaneous changes on several channels are filtered independently. Their pulses may coincide, and `changed` is then a single one-cycle high.
- All outputs are driven directly from flops; there is no combinational path from input to output.

## Structure

- Shared package `sensor_pkg` contains:
  - `N_SENSORS = 3`.
  - Channel index constants `SENSOR_L = 2`, `SENSOR_M = 1`, `SENSOR_R = 0`.
  - Default values for `SYNC_STAGES` and `STABLE_CYCLES`.
  - The top-level controller uses these constants to index `sensor_out`.
- Sub-module `sensor_filter_ch` holds one channel: synchroniser chain, counter, output flop and edge flops. `sensor_filter` instantiates it `N_CH` times in a generate loop and registers `changed`.

## Test plan

- Reset, then hold `sensor_in=3'b000` for 20 cycles → all outputs stay 0, and `rise`, `fall` and `changed` are never asserted.
- Defaults; set `sensor_in=3'b010` before edge 1 and hold → `sensor_out=3'b010` after edge 6; `rise=3'b010` and `changed=1` for exactly that cycle; nothing asserts afterwards.
- Defaults; 3-cycle high pulse on channel 0 → `sensor_out` stays 0 with no pulses. A 4-cycle pulse → `sensor_out[0]` is high from edge 6 to edge 10, with `rise[0]` at edge 6 and `fall[0]` at edge 10.
- Defaults; channel 2 bounces 1,1,0,1,1,1,1 → the count restarts at the 0, and the output rises 4 edges after the final run of 1s reaches `s`, not earlier.
- Defaults; all three channels go high together → a single cycle with `rise=3'b111` and `changed=1`.
- Defaults; assert `reset` at edge 4 during a pending 0→1 transition, release at edge 5, input still 1 → no pulse around the reset; `rise` fires at edge 11 (edge 5 + 6).
